// File: rtl/color_scan_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : color_scan_arbiter_pkg
// Brief    : Shared state encoding, color codes and default parameters.
// Revision : 1.0
// ============================================================================
package color_scan_arbiter_pkg;

    localparam int NUM_REQ_DEFAULT       = 4;
    localparam int SETTLE_TICKS_DEFAULT  = 1024;
    localparam int TIMEOUT_TICKS_DEFAULT = 5000000;
    localparam int CNT_W                 = 24;

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_SETTLE    = 3'd1;
    localparam logic [2:0] S_START     = 3'd2;
    localparam logic [2:0] S_WAIT_DONE = 3'd3;
    localparam logic [2:0] S_RESPOND   = 3'd4;

    typedef enum logic [1:0] {
        COLOR_RED    = 2'b00,
        COLOR_GREEN  = 2'b01,
        COLOR_BLUE   = 2'b10,
        COLOR_YELLOW = 2'b11
    } color_e;

endpackage
`default_nettype wire

// File: rtl/color_scan_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : color_scan_arbiter_if
// Brief    : Requester and color-detector signals of the scan arbiter.
// Revision : 1.0
// ============================================================================
interface color_scan_arbiter_if
    import color_scan_arbiter_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEFAULT
) ();
    localparam int IDX_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0] request;
    logic [NUM_REQ-1:0] acknowledge;
    logic [1:0]         resultColor;
    logic               resultTimeout;
    logic [IDX_W-1:0]   activeRequester;
    logic               busy;
    logic               ledEnable;
    logic               startDetection;
    logic               sensorReset;
    logic               detectionComplete;
    logic [1:0]         detectedColor;

    modport slave (
        input  request, detectionComplete, detectedColor,
        output acknowledge, resultColor, resultTimeout, activeRequester,
               busy, ledEnable, startDetection, sensorReset
    );

    modport master (
        output request, detectionComplete, detectedColor,
        input  acknowledge, resultColor, resultTimeout, activeRequester,
               busy, ledEnable, startDetection, sensorReset
    );
endinterface
`default_nettype wire

// File: rtl/color_scan_arbiter_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Brief    : Combinational round-robin pick starting after the last grant.
// Revision : 1.0
// ============================================================================
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  wire logic [NUM_REQ-1:0] i_req,
    input  wire logic [IDX_W-1:0]   i_last,
    output logic      [NUM_REQ-1:0] o_grant,
    output logic      [IDX_W-1:0]   o_idx,
    output logic                    o_valid
);
    always_comb begin
        int                 sum;
        logic [IDX_W-1:0]   cand;
        o_grant = '0;
        o_idx   = '0;
        o_valid = 1'b0;
        sum     = 0;
        cand    = '0;
        // Walk the ring from last+1, wrapping, and take the first requester.
        for (int i = 1; i <= NUM_REQ; i++) begin
            sum = int'(i_last) + i;
            if (sum >= NUM_REQ) begin
                sum = sum - NUM_REQ;
            end
            cand = IDX_W'(sum);
            if (!o_valid && i_req[cand]) begin
                o_valid       = 1'b1;
                o_grant[cand] = 1'b1;
                o_idx         = cand;
            end
        end
    end
endmodule
`default_nettype wire

// File: rtl/color_scan_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : color_scan_arbiter
// Brief    : Shares one color sensor among NUM_REQ requesters, round-robin.
// Revision : 1.0
// ============================================================================
module color_scan_arbiter
    import color_scan_arbiter_pkg::*;
#(
    parameter int NUM_REQ       = NUM_REQ_DEFAULT,
    parameter int SETTLE_TICKS  = SETTLE_TICKS_DEFAULT,
    parameter int TIMEOUT_TICKS = TIMEOUT_TICKS_DEFAULT
) (
    input wire logic            clk,
    input wire logic            reset,
    color_scan_arbiter_if.slave bus
);
    localparam int IDX_W = $clog2(NUM_REQ);
    localparam logic [CNT_W-1:0] c_SETTLE_LAST  = CNT_W'(SETTLE_TICKS - 1);
    localparam logic [CNT_W-1:0] c_TIMEOUT_LAST = CNT_W'(TIMEOUT_TICKS - 1);

    logic [2:0]         r_state;
    logic [2:0]         w_next_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [IDX_W-1:0]   r_last;
    logic [IDX_W-1:0]   r_active;
    logic [NUM_REQ-1:0] r_grant_oh;
    logic [1:0]         r_color;
    logic               r_timeout;
    logic               r_sensor_reset;

    logic [NUM_REQ-1:0] w_grant;
    logic [IDX_W-1:0]   w_grant_idx;
    logic               w_grant_valid;
    logic               w_timeout_hit;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_arbiter (
        .i_req   (bus.request),
        .i_last  (r_last),
        .o_grant (w_grant),
        .o_idx   (w_grant_idx),
        .o_valid (w_grant_valid)
    );

    // A completion in the final wait cycle takes priority over the timeout.
    assign w_timeout_hit = (r_state == S_WAIT_DONE) && !bus.detectionComplete &&
                           (r_cnt == c_TIMEOUT_LAST);

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:      if (w_grant_valid) w_next_state = S_SETTLE;
            S_SETTLE:    if (r_cnt == c_SETTLE_LAST) w_next_state = S_START;
            S_START:     w_next_state = S_WAIT_DONE;
            S_WAIT_DONE: if (bus.detectionComplete || (r_cnt == c_TIMEOUT_LAST))
                             w_next_state = S_RESPOND;
            S_RESPOND:   w_next_state = S_IDLE;
            default:     w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state        <= S_IDLE;
            r_cnt          <= '0;
            r_last         <= IDX_W'(NUM_REQ - 1);
            r_active       <= '0;
            r_grant_oh     <= '0;
            r_color        <= COLOR_RED;
            r_timeout      <= 1'b0;
            r_sensor_reset <= 1'b0;
        end else begin
            r_state        <= w_next_state;
            r_sensor_reset <= w_timeout_hit;
            // Counter restarts on every state change and saturates instead of wrapping.
            if (w_next_state != r_state) begin
                r_cnt <= '0;
            end else if (((r_state == S_SETTLE) || (r_state == S_WAIT_DONE)) && (r_cnt != '1)) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if ((r_state == S_IDLE) && w_grant_valid) begin
                r_active   <= w_grant_idx;
                r_grant_oh <= w_grant;
            end
            if ((r_state == S_WAIT_DONE) && bus.detectionComplete) begin
                r_color   <= bus.detectedColor;
                r_timeout <= 1'b0;
            end else if (w_timeout_hit) begin
                r_timeout <= 1'b1;
            end
            if (r_state == S_RESPOND) begin
                r_last <= r_active;
            end
        end
    end

    assign bus.acknowledge     = (r_state == S_RESPOND) ? r_grant_oh : '0;
    assign bus.resultColor     = r_color;
    assign bus.resultTimeout   = r_timeout;
    assign bus.activeRequester = r_active;
    assign bus.busy            = (r_state != S_IDLE);
    assign bus.ledEnable       = (r_state == S_SETTLE) || (r_state == S_START) ||
                                 (r_state == S_WAIT_DONE);
    assign bus.startDetection  = (r_state == S_START);
    assign bus.sensorReset     = r_sensor_reset;
endmodule
`default_nettype wire

// File: tb/tb_color_scan_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_color_scan_arbiter
// Brief    : Table-driven and randomized self-checking bench for the arbiter.
// Revision : 1.0
// ============================================================================
module tb_color_scan_arbiter;
    localparam int NREQ   = 4;
    localparam int SETTLE = 4;
    localparam int TMO    = 16;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    color_scan_arbiter_if #(.NUM_REQ(NREQ)) bus ();

    color_scan_arbiter #(
        .NUM_REQ       (NREQ),
        .SETTLE_TICKS  (SETTLE),
        .TIMEOUT_TICKS (TMO)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [3:0] req;
        int         done_at;   // wait-cycle index of the done pulse, -1 = never
        logic [1:0] col;
        bit         drop;
        int         exp_idx;
        logic [1:0] exp_col;
        bit         exp_to;
    } vec_t;

    vec_t tbl[12];

    int         m_last;
    logic [1:0] m_color;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int model_pick(input logic [3:0] req, input int last);
        for (int k = 1; k <= NREQ; k++) begin
            int c;
            c = (last + k) % NREQ;
            if (req[c]) return c;
        end
        return -1;
    endfunction

    task automatic do_scan(input logic [3:0] req, input int done_at, input logic [1:0] col,
                           input bit drop, input int exp_idx, input logic [1:0] exp_col,
                           input bit exp_to);
        logic [31:0] ack_exp;
        ack_exp = 32'd1 << exp_idx;
        bus.request = req;
        @(posedge clk); #1;
        check("grant_busy", bus.busy, 1);
        check("grant_led", bus.ledEnable, 1);
        check("grant_idx", bus.activeRequester, exp_idx);
        if (drop) bus.request = '0;
        for (int k = 1; k <= SETTLE; k++) begin
            @(posedge clk); #1;
            check("start_timing", bus.startDetection, (k == SETTLE));
        end
        @(posedge clk); #1;
        check("wait_start_low", bus.startDetection, 0);
        check("wait_led", bus.ledEnable, 1);
        for (int c = 0; c < TMO; c++) begin
            if (c == done_at) begin
                bus.detectionComplete = 1'b1;
                bus.detectedColor     = col;
            end
            @(posedge clk); #1;
            bus.detectionComplete = 1'b0;
            bus.detectedColor     = 2'($urandom);
            if (c == done_at) break;
        end
        check("resp_ack", bus.acknowledge, ack_exp);
        check("resp_color", bus.resultColor, exp_col);
        check("resp_timeout", bus.resultTimeout, exp_to);
        check("resp_sensor_reset", bus.sensorReset, exp_to);
        check("resp_led", bus.ledEnable, 0);
        @(posedge clk); #1;
        check("after_ack", bus.acknowledge, 0);
        check("after_busy", bus.busy, 0);
        check("after_sensor_reset", bus.sensorReset, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, busy=%0b", bus.busy);
        $fatal(1, "watchdog");
    end

    initial begin
        reset                 = 1'b1;
        bus.request           = '0;
        bus.detectionComplete = 1'b0;
        bus.detectedColor     = 2'b00;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ack", bus.acknowledge, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_led", bus.ledEnable, 0);
        check("rst_start", bus.startDetection, 0);
        check("rst_sensor_reset", bus.sensorReset, 0);
        check("rst_color", bus.resultColor, 0);
        check("rst_timeout", bus.resultTimeout, 0);
        check("rst_active", bus.activeRequester, 0);
        @(negedge clk) reset = 1'b0;
        @(posedge clk); #1;
        check("idle_busy", bus.busy, 0);

        // Expectations worked out by hand from reset (lastGrant=3, color=00).
        tbl[0]  = '{4'b1111,  2, 2'b01, 1'b0, 0, 2'b01, 1'b0};
        tbl[1]  = '{4'b1111,  0, 2'b11, 1'b0, 1, 2'b11, 1'b0};
        tbl[2]  = '{4'b1111,  5, 2'b00, 1'b0, 2, 2'b00, 1'b0};
        tbl[3]  = '{4'b1111,  7, 2'b10, 1'b0, 3, 2'b10, 1'b0};
        tbl[4]  = '{4'b1111,  1, 2'b01, 1'b0, 0, 2'b01, 1'b0};
        tbl[5]  = '{4'b0100,  4, 2'b10, 1'b0, 2, 2'b10, 1'b0};
        tbl[6]  = '{4'b0110, -1, 2'b00, 1'b0, 1, 2'b10, 1'b1};
        tbl[7]  = '{4'b0110, 15, 2'b11, 1'b0, 2, 2'b11, 1'b0};
        tbl[8]  = '{4'b1001,  3, 2'b00, 1'b1, 3, 2'b00, 1'b0};
        tbl[9]  = '{4'b0011, -1, 2'b01, 1'b0, 0, 2'b00, 1'b1};
        tbl[10] = '{4'b0001,  0, 2'b10, 1'b0, 0, 2'b10, 1'b0};
        tbl[11] = '{4'b1010,  6, 2'b01, 1'b0, 1, 2'b01, 1'b0};
        for (int i = 0; i < 12; i++) begin
            do_scan(tbl[i].req, tbl[i].done_at, tbl[i].col, tbl[i].drop,
                    tbl[i].exp_idx, tbl[i].exp_col, tbl[i].exp_to);
        end
        bus.request = '0;

        // Spurious completion while idle must not start anything or change the color.
        @(posedge clk); #1;
        bus.detectionComplete = 1'b1;
        bus.detectedColor     = 2'b11;
        @(posedge clk); #1;
        bus.detectionComplete = 1'b0;
        for (int k = 0; k < 2; k++) begin
            check("spur_busy", bus.busy, 0);
            check("spur_ack", bus.acknowledge, 0);
            check("spur_color", bus.resultColor, 2'b01);
            @(posedge clk); #1;
        end

        // Reset while waiting for the detector: everything clears at once.
        bus.request = 4'b0100;
        @(posedge clk); #1;
        check("rw_grant_idx", bus.activeRequester, 2);
        bus.request = '0;
        repeat (SETTLE + 1) @(posedge clk);
        #1;
        check("rw_in_wait_led", bus.ledEnable, 1);
        check("rw_in_wait_start", bus.startDetection, 0);
        #2;
        reset = 1'b1;
        #1;
        check("rw_busy", bus.busy, 0);
        check("rw_led", bus.ledEnable, 0);
        check("rw_ack", bus.acknowledge, 0);
        check("rw_color", bus.resultColor, 0);
        check("rw_timeout", bus.resultTimeout, 0);
        check("rw_active", bus.activeRequester, 0);
        repeat (2) @(posedge clk);
        #1;
        check("rw_ack_held", bus.acknowledge, 0);
        @(negedge clk) reset = 1'b0;
        m_last  = NREQ - 1;
        m_color = 2'b00;

        for (int n = 0; n < 40; n++) begin
            logic [3:0] req;
            int         d;
            logic [1:0] col;
            bit         drop;
            int         idx;
            bit         to;
            logic [1:0] ecol;
            req  = 4'($urandom_range(1, 15));
            d    = int'($urandom_range(0, 19));
            col  = 2'($urandom);
            drop = 1'($urandom_range(0, 1));
            idx  = model_pick(req, m_last);
            to   = (d >= TMO);
            ecol = to ? m_color : col;
            do_scan(req, d, col, drop, idx, ecol, to);
            m_last  = idx;
            m_color = ecol;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
